// File: rtl/fifo_rd_adapter_pkg.sv
// Shared types and constants for the FIFO read-side adapter.
// The buffer presents Dataout exactly RD_LAT cycles after an accepted Rden.
package fifo_rd_adapter_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CNT_W  = 16;
  localparam int RD_LAT     = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    state_t     state;
    logic [1:0] occupancy;
    logic       inflight;
  } dbg_t;

  // A read may be issued only if the word it returns is guaranteed a skid slot.
  function automatic logic has_room(input logic [1:0] occupancy,
                                    input logic       inflight,
                                    input logic       pop);
    logic [2:0] committed;
    committed = {1'b0, occupancy} + {2'b00, inflight} - {2'b00, pop};
    return committed < 3'd2;
  endfunction

endpackage

// File: rtl/fifo_rd_adapter_skid_buf2.sv
// Two-entry register FIFO that absorbs words already requested from the buffer
// while the downstream consumer is stalled.
module skid_buf2
  import fifo_rd_adapter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        occupancy
);

  logic [DATA_W-1:0] mem [2];
  logic              head;
  logic              tail;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop && (occupancy != 2'd0) && !clear;
  assign do_push = push && !clear && ((occupancy != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]    <= '0;
      mem[1]    <= '0;
      head      <= 1'b0;
      tail      <= 1'b0;
      occupancy <= 2'd0;
    end else if (clear) begin
      head      <= 1'b0;
      tail      <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      if (do_push) begin
        mem[tail] <= push_data;
        tail      <= ~tail;
      end
      if (do_pop) begin
        head <= ~head;
      end
      occupancy <= occupancy + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Head register is only rewritten by a push into the other slot, so it stays put under stall.
  assign head_data = mem[head];

endmodule

// File: rtl/fifo_rd_adapter.sv
// Read-side master for the 32-bit FIFO/LIFO buffer: issues Rden against Empty,
// captures Dataout one cycle later and presents it as a valid/ready stream.
module fifo_rd_adapter
  import fifo_rd_adapter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Enable,
  input  logic              Flush,
  input  logic              Empty,
  input  logic [DATA_W-1:0] Fifo_data,
  output logic              Rden,
  output logic [DATA_W-1:0] Out_data,
  output logic              Out_valid,
  input  logic              Out_ready,
  output logic [CNT_W-1:0]  Rd_count,
  output logic              Busy,
  output dbg_t              Dbg
);

  // Stream handshake: a word moves on every rising Clk where Out_valid and
  // Out_ready are both high; Out_data is held while Out_valid=1 and Out_ready=0.

  state_t            state;
  state_t            state_next;
  logic [RD_LAT-1:0] rd_pipe;
  logic              inflight;
  logic [1:0]        occupancy;
  logic              pop;
  logic              capture;
  logic              clear;

  assign inflight  = rd_pipe[RD_LAT-1];
  assign pop       = Out_valid & Out_ready;
  assign clear     = (state == ST_FLUSH);
  assign capture   = inflight & ~clear;
  assign Out_valid = (occupancy != 2'd0) && (state != ST_FLUSH);
  assign Busy      = (state != ST_IDLE) || (occupancy != 2'd0);
  assign Rden      = (state == ST_RUN) && !Empty && has_room(occupancy, inflight, pop);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (Flush) begin
          state_next = ST_FLUSH;
        end else if (Enable) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (Flush) begin
          state_next = ST_FLUSH;
        end else if (!Enable) begin
          state_next = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        // Stay until the last requested word has landed and been dropped.
        if (!inflight && !Flush) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rd_pipe  <= '0;
      Rd_count <= '0;
    end else begin
      rd_pipe <= RD_LAT'(Rden);
      if (Rden) begin
        Rd_count <= Rd_count + CNT_W'(1);
      end
    end
  end

  skid_buf2 #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk      (Clk),
    .rst_n    (Rst),
    .clear    (clear),
    .push     (capture),
    .push_data(Fifo_data),
    .pop      (pop),
    .head_data(Out_data),
    .occupancy(occupancy)
  );

  assign Dbg.state     = state;
  assign Dbg.occupancy = occupancy;
  assign Dbg.inflight  = inflight;

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Directed bench for fifo_rd_adapter: models the 1-cycle-latency buffer and
// checks the stream against an expected-word queue.
module tb_fifo_rd_adapter;
  import fifo_rd_adapter_pkg::*;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  // clock / reset
  logic              Clk = 1'b0;
  logic              Rst;
  logic              Enable;
  logic              Flush;
  logic              Empty;
  logic [DATA_W-1:0] Fifo_data;
  logic              Rden;
  logic [DATA_W-1:0] Out_data;
  logic              Out_valid;
  logic              Out_ready;
  logic [CNT_W-1:0]  Rd_count;
  logic              Busy;
  dbg_t              Dbg;

  always #5 Clk = ~Clk;

  fifo_rd_adapter #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Enable   (Enable),
    .Flush    (Flush),
    .Empty    (Empty),
    .Fifo_data(Fifo_data),
    .Rden     (Rden),
    .Out_data (Out_data),
    .Out_valid(Out_valid),
    .Out_ready(Out_ready),
    .Rd_count (Rd_count),
    .Busy     (Busy),
    .Dbg      (Dbg)
  );

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] buf_q[$];
  logic [DATA_W-1:0] exp_q[$];

  // scoreboard
  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock: score a stream pop, model the buffer read port, settle to the falling edge.
  task automatic tick();
    if (Out_valid && Out_ready) begin
      if (exp_q.size() == 0) check("stream_extra_word", 64'(exp_q.size()), 64'd1);
      else check("stream_data", 64'(Out_data), 64'(exp_q.pop_front()));
    end
    @(posedge Clk);
    if (Rden) begin
      if (buf_q.size() == 0) check("read_while_empty", 64'(buf_q.size()), 64'd1);
      else begin
        Fifo_data <= buf_q.pop_front();
        Empty     <= (buf_q.size() == 0);
      end
    end
    @(negedge Clk);
    check("occupancy_bound", 64'(Dbg.occupancy <= 2'd2), 64'd1);
  endtask

  // driver tasks
  task automatic write_word(input logic [DATA_W-1:0] w, input logic expect_out);
    buf_q.push_back(w);
    Empty = 1'b0;
    if (expect_out) exp_q.push_back(w);
  endtask

  task automatic do_reset();
    Rst       = 1'b0;
    Enable    = 1'b0;
    Flush     = 1'b0;
    Out_ready = 1'b0;
    Empty     = 1'b1;
    buf_q.delete();
    exp_q.delete();
    #1;
    tick();
    Rst = 1'b1;
    tick();
  endtask

  task automatic drain(input int budget);
    for (int n = 0; n < budget && exp_q.size() != 0; n++) tick();
    check("drain_done", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    Rst = 1'b0; Enable = 1'b0; Flush = 1'b0; Empty = 1'b1;
    Out_ready = 1'b0; Fifo_data = '0;
    #1;
    check("rst_rden", 64'(Rden), 64'd0);
    check("rst_out_valid", 64'(Out_valid), 64'd0);
    check("rst_out_data", 64'(Out_data), 64'd0);
    check("rst_rd_count", 64'(Rd_count), 64'd0);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_state", 64'(Dbg.state), 64'(ST_IDLE));
    tick();
    Rst = 1'b1;
    tick();

    // Streaming
    for (int i = 0; i < 4; i++) write_word(32'h11111111 * (i + 1), 1'b1);
    Out_ready = 1'b1; Enable = 1'b1;
    #1;
    check("st_rden_idle", 64'(Rden), 64'd0);
    tick();
    check("st_c1_rden", 64'(Rden), 64'd1);
    check("st_c1_state", 64'(Dbg.state), 64'(ST_RUN));
    check("st_c1_valid", 64'(Out_valid), 64'd0);
    tick();
    check("st_c2_rden", 64'(Rden), 64'd1);
    check("st_c2_valid", 64'(Out_valid), 64'd0);
    check("st_c2_count", 64'(Rd_count), 64'd1);
    tick();
    check("st_c3_rden", 64'(Rden), 64'd1);
    check("st_c3_valid", 64'(Out_valid), 64'd1);
    check("st_c3_data", 64'(Out_data), 64'h11111111);
    check("st_c3_count", 64'(Rd_count), 64'd2);
    tick();
    check("st_c4_rden", 64'(Rden), 64'd1);
    check("st_c4_data", 64'(Out_data), 64'h22222222);
    check("st_c4_count", 64'(Rd_count), 64'd3);
    tick();
    check("st_c5_rden", 64'(Rden), 64'd0);
    check("st_c5_data", 64'(Out_data), 64'h33333333);
    check("st_c5_count", 64'(Rd_count), 64'd4);
    Enable = 1'b0;
    tick();
    check("st_c6_valid", 64'(Out_valid), 64'd1);
    check("st_c6_data", 64'(Out_data), 64'h44444444);
    check("st_c6_busy", 64'(Busy), 64'd1);
    check("st_c6_state", 64'(Dbg.state), 64'(ST_IDLE));
    tick();
    check("st_c7_valid", 64'(Out_valid), 64'd0);
    check("st_c7_busy", 64'(Busy), 64'd0);
    check("st_c7_count", 64'(Rd_count), 64'd4);
    check("st_all_out", 64'(exp_q.size()), 64'd0);

    // Backpressure
    do_reset();
    for (int i = 0; i < 4; i++) write_word(32'h11111111 * (i + 1), 1'b1);
    Enable = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    check("bp_rden_stall", 64'(Rden), 64'd0);
    check("bp_count", 64'(Rd_count), 64'd2);
    check("bp_occ", 64'(Dbg.occupancy), 64'd2);
    check("bp_valid", 64'(Out_valid), 64'd1);
    check("bp_head_held", 64'(Out_data), 64'h11111111);
    Out_ready = 1'b1;
    #1;
    check("bp_release_rden", 64'(Rden), 64'd1);
    drain(20);
    check("bp_final_count", 64'(Rd_count), 64'd4);
    check("bp_final_valid", 64'(Out_valid), 64'd0);
    Enable = 1'b0;

    // Empty boundary
    do_reset();
    write_word(32'hDEADBEEF, 1'b1);
    Out_ready = 1'b1; Enable = 1'b1;
    tick();
    check("em_c1_rden", 64'(Rden), 64'd1);
    tick();
    check("em_c2_rden", 64'(Rden), 64'd0);
    check("em_c2_count", 64'(Rd_count), 64'd1);
    tick();
    check("em_c3_data", 64'(Out_data), 64'hDEADBEEF);
    check("em_c3_valid", 64'(Out_valid), 64'd1);
    tick(); tick();
    check("em_idle_rden", 64'(Rden), 64'd0);
    check("em_idle_valid", 64'(Out_valid), 64'd0);
    write_word(32'hCAFEF00D, 1'b1);
    #1;
    check("em_refill_rden", 64'(Rden), 64'd1);
    tick();
    check("em_refill_count", 64'(Rd_count), 64'd2);
    tick();
    check("em_refill_data", 64'(Out_data), 64'hCAFEF00D);
    drain(4);
    Enable = 1'b0;

    // Flush with a word still in flight
    do_reset();
    write_word(32'h11111111, 1'b1);
    for (int i = 1; i < 4; i++) write_word(32'h11111111 * (i + 1), 1'b0);
    Out_ready = 1'b1; Enable = 1'b1;
    tick(); tick(); tick();
    check("fl_pre_count", 64'(Rd_count), 64'd2);
    Flush = 1'b1; Enable = 1'b0;
    #1;
    check("fl_pulse_rden", 64'(Rden), 64'd1);
    tick();
    Flush = 1'b0;
    check("fl_f1_state", 64'(Dbg.state), 64'(ST_FLUSH));
    check("fl_f1_valid", 64'(Out_valid), 64'd0);
    check("fl_f1_rden", 64'(Rden), 64'd0);
    check("fl_f1_inflight", 64'(Dbg.inflight), 64'd1);
    check("fl_f1_count", 64'(Rd_count), 64'd3);
    tick();
    check("fl_f2_state", 64'(Dbg.state), 64'(ST_FLUSH));
    check("fl_f2_occ", 64'(Dbg.occupancy), 64'd0);
    check("fl_f2_valid", 64'(Out_valid), 64'd0);
    check("fl_f2_busy", 64'(Busy), 64'd1);
    tick();
    check("fl_end_state", 64'(Dbg.state), 64'(ST_IDLE));
    check("fl_end_occ", 64'(Dbg.occupancy), 64'd0);
    check("fl_end_busy", 64'(Busy), 64'd0);
    check("fl_end_count", 64'(Rd_count), 64'd3);
    check("fl_end_rden", 64'(Rden), 64'd0);
    check("fl_only_first", 64'(exp_q.size()), 64'd0);

    // Counter wrap at CNT_W=4
    do_reset();
    for (int i = 0; i < 17; i++) write_word(32'hA5000000 + i, 1'b1);
    Out_ready = 1'b1; Enable = 1'b1;
    drain(60);
    Enable = 1'b0;
    check("wrap_count", 64'(Rd_count), 64'd1);

    // Asynchronous reset mid-stream
    do_reset();
    write_word(32'hB0000000, 1'b1);
    for (int i = 1; i < 6; i++) write_word(32'hB0000000 + i, 1'b0);
    Out_ready = 1'b1; Enable = 1'b1;
    tick(); tick(); tick(); tick();
    check("ar_pre_count", 64'(Rd_count), 64'd3);
    check("ar_pre_data", 64'(Out_data), 64'hB0000001);
    #2;
    Rst = 1'b0;
    #1;
    check("ar_rden", 64'(Rden), 64'd0);
    check("ar_valid", 64'(Out_valid), 64'd0);
    check("ar_data", 64'(Out_data), 64'd0);
    check("ar_count", 64'(Rd_count), 64'd0);
    check("ar_busy", 64'(Busy), 64'd0);
    check("ar_state", 64'(Dbg.state), 64'(ST_IDLE));
    for (int i = 3; i < 6; i++) exp_q.push_back(32'hB0000000 + i);
    tick();
    Rst = 1'b1;
    drain(20);
    check("ar_resume_count", 64'(Rd_count), 64'd3);
    Enable = 1'b0;
    tick();

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
